pipe_cla_addsub: RTL and testbench
==================================

PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 SHALL have parameter N, default 32: operand width in bits.
REQ-002 SHALL have parameter S, default 4: pipeline stage count; N SHALL be divisible by S, and elaboration SHALL fail otherwise.
REQ-003 SHALL have parameter G, default 4: lookahead group size inside each slice; N/S SHALL be divisible by G.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  an operand set is present on the inputs.
REQ-007 in_ready  out  1  block accepts the operand set this cycle.
REQ-008 x  in  N  operand A.
REQ-009 y  in  N  operand B.
REQ-010 cin  in  1  carry-in; used only in add mode.
REQ-011 sub  in  1  mode select: 0 = add, 1 = subtract.
REQ-012 out_valid  out  1  a result is present on the outputs.
REQ-013 out_ready  in  1  downstream accepts the result this cycle.
REQ-014 sum  out  N  result.
REQ-015 cout  out  1  carry out of bit N-1.
REQ-016 ovf  out  1  two's-complement signed overflow.

Function
REQ-017 Add mode SHALL compute {cout,sum} = x + y + cin.
REQ-018 Subtract mode SHALL compute x + ~y + 1 and ignore cin; cout=1 SHALL mean no borrow.
REQ-019 ovf SHALL equal the carry into bit N-1 XOR the carry out of bit N-1.
REQ-020 Stage k (k = 0..S-1) SHALL add bits [k*W +: W], W = N/S, using W-bit group lookahead: per-bit p = a^b and g = a&b, and group P/G per G bits.
REQ-021 Stage k SHALL take its carry-in from the registered carry of stage k-1; stage 0 SHALL take cin, or 1 in subtract mode.
REQ-022 Each stage register SHALL carry the unprocessed upper operand bits, the completed lower sum bits, the carry, the carry into the top bit, and a valid flag.
REQ-023 Latency from an in_valid&&in_ready cycle to out_valid SHALL be exactly S cycles when out_ready is held high.
REQ-024 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-025 Stage k SHALL advance when it is empty or stage k+1 advances; the last stage SHALL advance when it is empty or out_ready=1.
REQ-026 in_ready SHALL equal the advance condition of stage 0, computed combinationally; there SHALL be no bubble insertion.
REQ-027 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL hold stable, and no in-flight operand SHALL be lost or duplicated.
REQ-028 Operands SHALL be accepted only when in_valid && in_ready; x, y, cin and sub are don't-care otherwise.
REQ-029 Results SHALL emerge in acceptance order.
REQ-030 Wrap-around SHALL be modulo 2^N; the carry beyond bit N-1 SHALL appear only on cout.
REQ-031 A simultaneous input accept and output accept when all stages are full SHALL be legal and SHALL keep occupancy at S.

Reset
REQ-032 When rst_n=0 at a clock edge, all stage valid flags SHALL clear and all data registers SHALL clear to 0.
REQ-033 From the cycle after reset until the first result, out_valid SHALL be 0 and sum, cout and ovf SHALL be 0.
REQ-034 A reset asserted mid-operation SHALL discard all in-flight results without emitting them.
REQ-035 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-036 A shared package pipe_cla_pkg SHALL hold the default N, S and G constants and the mode encoding (MODE_ADD = 0, MODE_SUB = 1).
REQ-037 The combinational W-bit group-lookahead adder SHALL be one sub-module, cla_slice (inputs a, b, ci; outputs s, co, c_msb), instantiated S times by a generate loop.

Verification
REQ-038 N=32, S=4; add x=0xFFFFFFFF, y=1, cin=0 -> after 4 cycles sum=0, cout=1, ovf=0.
REQ-039 Subtract x=0x80000000, y=1 -> sum=0x7FFFFFFF, cout=1, ovf=1; subtract x=0, y=1 -> sum=0xFFFFFFFF, cout=0, ovf=0.
REQ-040 Stream 8 back-to-back adds i+i (i = 0..7) with out_ready=1 -> 8 consecutive valid results 0,2,...,14, first appearing 4 cycles after the first accept.
REQ-041 Fill the pipe, then hold out_ready=0 for 5 cycles -> in_ready goes 0 after 4 accepts, outputs stay stable, and the results drain in order after release.
REQ-042 Assert rst_n=0 with 3 results in flight -> no result is emitted and out_valid=0; after release, one add 5+7+1 -> sum=13.
REQ-043 Random constrained ops with random in_valid and out_ready, for S in {1,2,4,8}, checked against a scoreboard model; 10k transactions with zero mismatches.

Source files
------------

// File: rtl/pipe_cla_pkg.sv
// rtl/pipe_cla_pkg.sv - shared constants and mode encoding for the pipelined CLA adder/subtractor
//
// Purpose: default operand width, stage count and lookahead group size,
//          plus the add/subtract mode encoding used on the sub input.
// Ports:   none (package).

package pipe_cla_pkg;

    localparam int N_DEF = 32;  // operand width
    localparam int S_DEF = 4;   // pipeline stages
    localparam int G_DEF = 4;   // lookahead group size inside a slice

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - combinational W-bit group carry-lookahead adder slice
//
// Purpose: adds two W-bit values plus a carry-in using per-bit propagate and
//          generate, collapsed into group propagate/generate every G bits.
// Ports:   a, b   - W-bit addends
//          ci     - carry into bit 0
//          s      - W-bit sum
//          co     - carry out of bit W-1
//          c_msb  - carry into bit W-1 (used for signed overflow)

module cla_slice #(
    parameter int W = 8,
    parameter int G = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    localparam int NG = W / G;

    logic [W-1:0]  p;
    logic [W-1:0]  g;
    logic [W-1:0]  c;       // carry into each bit
    logic [NG-1:0] gp;      // group propagate
    logic [NG-1:0] gg;      // group generate
    logic [NG:0]   gc;      // carry into each group

    always_comb begin
        p  = a ^ b;
        g  = a & b;
        gp = '0;
        gg = '0;
        gc = '0;
        c  = '0;

        for (int j = 0; j < NG; j++) begin
            gp[j] = &p[j*G +: G];
            // Fold the group's bits from LSB upward into a single generate term.
            for (int i = 0; i < G; i++) begin
                gg[j] = g[j*G+i] | (p[j*G+i] & gg[j]);
            end
        end

        gc[0] = ci;
        for (int j = 0; j < NG; j++) begin
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end

        // Bit carries inside a group start from the lookahead group carry.
        for (int j = 0; j < NG; j++) begin
            c[j*G] = gc[j];
            for (int i = 1; i < G; i++) begin
                c[j*G+i] = g[j*G+i-1] | (p[j*G+i-1] & c[j*G+i-1]);
            end
        end

        s     = p ^ c;
        co    = gc[NG];
        c_msb = c[W-1];
    end

endmodule

// File: rtl/pipe_cla_addsub.sv
// rtl/pipe_cla_addsub.sv - S-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control
//
// Purpose: each stage adds one W = N/S bit slice with a cla_slice and hands its
//          carry to the next stage through a register; operands not yet added
//          ride along with the partial sum.
// Ports:   clk, rst_n         - clock, synchronous active-low reset
//          in_valid/in_ready  - operand handshake (x, y, cin, sub)
//          sub                - 0 add (x+y+cin), 1 subtract (x+~y+1, cin ignored)
//          out_valid/out_ready- result handshake (sum, cout, ovf)
//          cout               - carry out of bit N-1 (1 = no borrow when subtracting)
//          ovf                - signed overflow

module pipe_cla_addsub
    import pipe_cla_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int S = S_DEF,
    parameter int G = G_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / S;

    if ((N % S) != 0 || (W % G) != 0) begin : g_bad_params
        $error("pipe_cla_addsub: N must divide by S and N/S by G");
    end

    // Stage registers: index k holds the state after slice k has been added.
    logic [N-1:0] a_q  [S];
    logic [N-1:0] a_d  [S];
    logic [N-1:0] b_q  [S];
    logic [N-1:0] b_d  [S];
    logic [N-1:0] s_q  [S];
    logic [N-1:0] s_d  [S];
    logic         cm_q [S];
    logic         cm_d [S];
    logic [S-1:0] c_q;
    logic [S-1:0] c_d;
    logic [S-1:0] v_q;
    logic [S-1:0] v_d;

    // Stage inputs: stage 0 reads the ports, stage k reads register k-1.
    logic [N-1:0] a_in  [S];
    logic [N-1:0] b_in  [S];
    logic [N-1:0] s_in  [S];
    logic [S-1:0] ci_in;
    logic [S-1:0] vi_in;

    logic [W-1:0] sl_s  [S];
    logic         sl_cm [S];
    logic [S-1:0] sl_co;

    logic [S:0]   adv;

    always_comb begin
        for (int k = 0; k < S; k++) begin
            a_in[k] = '0;
            b_in[k] = '0;
            s_in[k] = '0;
        end
        ci_in = '0;
        vi_in = '0;

        // Subtraction is x + ~y + 1: invert y once at entry and force carry-in.
        a_in[0]  = x;
        b_in[0]  = (sub == MODE_SUB) ? ~y : y;
        ci_in[0] = (sub == MODE_SUB) ? 1'b1 : cin;
        vi_in[0] = in_valid;
        for (int k = 1; k < S; k++) begin
            a_in[k]  = a_q[k-1];
            b_in[k]  = b_q[k-1];
            s_in[k]  = s_q[k-1];
            ci_in[k] = c_q[k-1];
            vi_in[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        cla_slice #(
            .W (W),
            .G (G)
        ) u_slice (
            .a     (a_in[k][k*W +: W]),
            .b     (b_in[k][k*W +: W]),
            .ci    (ci_in[k]),
            .s     (sl_s[k]),
            .co    (sl_co[k]),
            .c_msb (sl_cm[k])
        );
    end

    // A stage may load when it is empty or its occupant moves on this cycle.
    always_comb begin
        adv    = '0;
        adv[S] = out_ready;
        for (int k = S - 1; k >= 0; k--) begin
            adv[k] = !v_q[k] || adv[k+1];
        end
    end

    always_comb begin
        for (int k = 0; k < S; k++) begin
            a_d[k]  = a_q[k];
            b_d[k]  = b_q[k];
            s_d[k]  = s_q[k];
            cm_d[k] = cm_q[k];
        end
        c_d = c_q;
        v_d = v_q;

        for (int k = 0; k < S; k++) begin
            if (adv[k]) begin
                v_d[k] = vi_in[k];
                // Data only loads with a real operand so the outputs keep
                // their last value (zero after reset) across bubbles.
                if (vi_in[k]) begin
                    a_d[k]              = a_in[k];
                    b_d[k]              = b_in[k];
                    s_d[k]              = s_in[k];
                    s_d[k][k*W +: W]    = sl_s[k];
                    c_d[k]              = sl_co[k];
                    cm_d[k]             = sl_cm[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < S; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                s_q[k]  <= '0;
                cm_q[k] <= 1'b0;
            end
            c_q <= '0;
            v_q <= '0;
        end else begin
            for (int k = 0; k < S; k++) begin
                a_q[k]  <= a_d[k];
                b_q[k]  <= b_d[k];
                s_q[k]  <= s_d[k];
                cm_q[k] <= cm_d[k];
            end
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[S-1];
    assign sum       = s_q[S-1];
    assign cout      = c_q[S-1];
    assign ovf       = cm_q[S-1] ^ c_q[S-1];

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// tb/tb_pipe_cla_addsub.sv - scoreboard bench for pipe_cla_addsub at S = 1, 2, 4, 8

module tb_pipe_cla_addsub;
    import pipe_cla_pkg::*;

    localparam int N    = 32;
    localparam int NI   = 4;
    localparam int BASE = 2;   // instance with S = 4
    localparam int SB   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          cin;
    logic          sub;
    logic          out_ready;
    logic [N-1:0]  x;
    logic [N-1:0]  y;
    logic [NI-1:0] in_ready_v;
    logic [NI-1:0] out_valid_v;
    logic [NI-1:0] cout_v;
    logic [NI-1:0] ovf_v;
    logic [N-1:0]  sum_v [NI];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < NI; i++) begin : g_dut
        pipe_cla_addsub #(
            .N (N),
            .S (1 << i),
            .G (4)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[i]),
            .x         (x),
            .y         (y),
            .cin       (cin),
            .sub       (sub),
            .out_valid (out_valid_v[i]),
            .out_ready (out_ready),
            .sum       (sum_v[i]),
            .cout      (cout_v[i]),
            .ovf       (ovf_v[i])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; returns {cout, ovf, sum}.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic s);
        longint      sa;
        longint      sb;
        longint      ex;
        logic [32:0] u;
        logic        co;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            u  = {1'b0, a - b};
            co = (a >= b);
            ex = sa - sb;
        end else begin
            u  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
            co = u[32];
            ex = sa + sb + longint'(ci);
        end
        return {co, (ex > 64'sd2147483647) || (ex < -64'sd2147483648), u[31:0]};
    endfunction

    logic [33:0] sb_q [NI][$];
    int          acc_cnt [NI];
    int          acc_q [$];
    int          obs_cyc [$];
    logic [33:0] obs_val [$];

    // Scoreboard: push on every accept, pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) sb_q[i].delete();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (in_valid && in_ready_v[i]) begin
                    sb_q[i].push_back(model(x, y, cin, sub));
                    acc_cnt[i]++;
                    if (i == BASE) acc_q.push_back(cyc);
                end
                if (out_valid_v[i] && out_ready) begin
                    logic [33:0] act;
                    act = {cout_v[i], ovf_v[i], sum_v[i]};
                    if (i == BASE) begin
                        obs_cyc.push_back(cyc);
                        obs_val.push_back(act);
                    end
                    chk(sb_q[i].size() != 0, $sformatf("sb S=%0d output with nothing pending", 1 << i),
                        64'(out_valid_v[i]), 64'd0);
                    if (sb_q[i].size() != 0) begin
                        logic [33:0] e;
                        e = sb_q[i].pop_front();
                        chk(act == e, $sformatf("sb S=%0d {cout,ovf,sum}", 1 << i), 64'(act), 64'(e));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
        x = a; y = b; cin = c; sub = s; in_valid = 1'b1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        obs_cyc.delete();
        obs_val.delete();
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s,
                           input logic [31:0] es, input logic ec, input logic eo, input string nm);
        int n;
        clear_logs();
        drive(a, b, c, s);
        n = 0;
        while (acc_q.size() == 0 && n < 20) begin step(); n++; end
        in_valid = 1'b0;
        chk(acc_q.size() == 1, {nm, " accepted"}, 64'(acc_q.size()), 64'd1);
        n = 0;
        while (obs_val.size() == 0 && n < 30) begin step(); n++; end
        chk(obs_val.size() == 1, {nm, " output count"}, 64'(obs_val.size()), 64'd1);
        if (obs_val.size() != 0 && acc_q.size() != 0) begin
            chk(obs_val[0] == {ec, eo, es}, {nm, " {cout,ovf,sum}"}, 64'(obs_val[0]), 64'({ec, eo, es}));
            chk(obs_cyc[0] - acc_q[0] == SB, {nm, " latency"}, 64'(obs_cyc[0] - acc_q[0]), 64'(SB));
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        bit ok;
        logic [31:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; cin = 1'b0; sub = MODE_ADD;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk({out_valid_v[i], cout_v[i], ovf_v[i], sum_v[i]} == '0,
                $sformatf("reset outputs S=%0d", 1 << i),
                64'({out_valid_v[i], cout_v[i], ovf_v[i], sum_v[i]}), 64'd0);
            chk(in_ready_v[i] == 1'b1, $sformatf("reset in_ready S=%0d", 1 << i), 64'(in_ready_v[i]), 64'd1);
        end
        step();

        run_one(32'hFFFF_FFFF, 32'h1, 1'b0, MODE_ADD, 32'h0,         1'b1, 1'b0, "add wrap");
        run_one(32'h8000_0000, 32'h1, 1'b1, MODE_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub ovf");
        run_one(32'h0,         32'h1, 1'b1, MODE_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub borrow");

        // Back-to-back stream i+i.
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            drive(32'(i), 32'(i), 1'b0, MODE_ADD);
            step();
        end
        in_valid = 1'b0;
        chk(acc_q.size() == 8, "stream accepts", 64'(acc_q.size()), 64'd8);
        n = 0;
        while (obs_val.size() < 8 && n < 30) begin step(); n++; end
        chk(obs_val.size() == 8, "stream output count", 64'(obs_val.size()), 64'd8);
        if (obs_val.size() == 8 && acc_q.size() != 0) begin
            chk(obs_cyc[0] - acc_q[0] == SB, "stream first latency", 64'(obs_cyc[0] - acc_q[0]), 64'(SB));
            for (int k = 0; k < 8; k++) begin
                chk(obs_val[k] == 34'(2 * k), $sformatf("stream result %0d", k), 64'(obs_val[k]), 64'(2 * k));
                chk(obs_cyc[k] == obs_cyc[0] + k, $sformatf("stream cycle %0d", k),
                    64'(obs_cyc[k] - obs_cyc[0]), 64'(k));
            end
        end

        // Backpressure: fill, stall, then drain.
        clear_logs();
        out_ready = 1'b0;
        drive(32'd100, 32'd0, 1'b0, MODE_ADD);
        for (int i = 0; i < 6; i++) begin
            step();
            x = 32'd100 + 32'(acc_q.size());
        end
        chk(acc_q.size() == SB, "stall accepts", 64'(acc_q.size()), 64'(SB));
        chk(in_ready_v[BASE] == 1'b0, "stall in_ready", 64'(in_ready_v[BASE]), 64'd0);
        chk(out_valid_v[BASE] == 1'b1, "stall out_valid", 64'(out_valid_v[BASE]), 64'd1);
        held = sum_v[BASE];
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (sum_v[BASE] != held || out_valid_v[BASE] != 1'b1) ok = 1'b0;
        end
        chk(ok, "stall outputs stable", 64'(sum_v[BASE]), 64'(held));
        chk(held == 32'd100, "stall head value", 64'(held), 64'd100);
        chk(obs_val.size() == 0, "stall nothing emitted", 64'(obs_val.size()), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (obs_val.size() < SB && n < 30) begin step(); n++; end
        chk(obs_val.size() == SB, "drain count", 64'(obs_val.size()), 64'(SB));
        for (int k = 0; k < SB && k < obs_val.size(); k++) begin
            chk(obs_val[k] == 34'(100 + k), $sformatf("drain order %0d", k), 64'(obs_val[k]), 64'(100 + k));
        end

        // Reset with three results in flight.
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            drive(32'(i + 1), 32'd1, 1'b0, MODE_ADD);
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        chk(acc_q.size() == 3, "inflight accepts", 64'(acc_q.size()), 64'd3);
        step(); step();
        chk(out_valid_v == '0, "reset out_valid", 64'(out_valid_v), 64'd0);
        rst_n = 1'b1;
        repeat (6) step();
        chk(obs_val.size() == 0, "flushed results", 64'(obs_val.size()), 64'd0);
        run_one(32'd5, 32'd7, 1'b1, MODE_ADD, 32'd13, 1'b0, 1'b0, "post reset add");

        // Random traffic on all four depths.
        for (int i = 0; i < NI; i++) acc_cnt[i] = 0;
        n = 0;
        while (n < 60000 && (acc_cnt[0] < 10000 || acc_cnt[1] < 10000 ||
                             acc_cnt[2] < 10000 || acc_cnt[3] < 10000)) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            x   = pick();
            y   = pick();
            cin = 1'($urandom);
            sub = 1'($urandom);
            step();
            n++;
        end
        for (int i = 0; i < NI; i++) begin
            chk(acc_cnt[i] >= 10000, $sformatf("random accepts S=%0d", 1 << i), 64'(acc_cnt[i]), 64'd10000);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (n < 50 && (sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size()) != 0) begin
            step();
            n++;
        end
        for (int i = 0; i < NI; i++) begin
            chk(sb_q[i].size() == 0, $sformatf("drained S=%0d", 1 << i), 64'(sb_q[i].size()), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
